pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline-stage register for the pipelined datapath. It replaces the fixed per-stage latches with one reusable block carrying a data payload, a control bundle and a destination-register index. It adds a valid/ready handshake, flush-to-bubble and a saturating stall counter. It sits between any two stages (ID/EX, EX/MEM, MEM/WB) and is instantiated once per boundary.

## Interface
- DATA_W, 96: width of data payload (operands, immediate, source indices, packed by the instantiating stage)
- CTRL_W, 9: width of control bundle (ALU op, mux selects, MemWr, MemRd, WrReg, ...)
- REG_W, 5: width of destination-register index
- CNT_W, 16: width of stall counter

- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- flush  input  1  synchronous kill of all held and incoming entries
- in_valid  input  1  upstream entry present
- in_ready  output  1  block can accept an entry this cycle
- in_data  input  DATA_W  upstream payload
- in_ctrl  input  CTRL_W  upstream control bundle
- in_dest  input  REG_W  upstream destination index
- out_valid  output  1  entry presented downstream
- out_ready  input  1  downstream accepts entry this cycle
- out_data  output  DATA_W  registered payload
- out_ctrl  output  CTRL_W  registered control; forced to 0 whenever out_valid=0
- out_dest  output  REG_W  registered destination index
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- Storage: a main register drives the outputs. An optional skid register is described under Configuration.
- Main register loads when it is empty, or when it is being drained in the same cycle. Load sources, in priority order:
  - skid entry, if the skid register holds one;
  - otherwise in_* on an input transfer.
- Main register holds all fields unchanged while out_valid && !out_ready. This is the stall.
- Flush:
  - Clears out_valid, the skid valid bit and out_ctrl to 0. out_data and out_dest keep their values.
  - An input presented in the same cycle is discarded.
  - Flush has priority over every other event, including a simultaneous out transfer. Downstream must treat an entry shown in a flush cycle as wrong-path.
- out_ctrl is 0 whenever out_valid=0. A bubble therefore never writes memory or registers.
- stall_cnt:
  - Increments by 1 on each edge where out_valid && !out_ready && !flush.
  - Saturates at 2^CNT_W-1 and is not wrapped.
  - Cleared only by rst.
- Reset (rst=0, asynchronous):
  - out_valid, out_data, out_ctrl, out_dest, stall_cnt and the skid contents go to 0.
  - in_ready is forced to 0 while rst=0.

## Timing
- Latency: an entry accepted at edge N appears on out_* after edge N, i.e. one cycle, when the main register is free.
- Throughput: one entry per cycle with out_ready held at 1.
- Input drop: an in_valid pulse with in_ready=0 is not accepted. Upstream holds in_* stable until the transfer occurs.
- Reset mid-stall: all state is discarded immediately. First acceptance is possible at the first edge after rst returns to 1.

## Configuration
- PIPE_SKID_EN defined:
  - Two-entry buffer: main plus skid register.
  - in_ready = !skid_valid, a registered output with no combinational path from out_ready.
  - An input accepted while main is stalled goes to skid.
  - On the next out transfer, skid moves to main. A new input is accepted in that cycle only if skid was empty.
- PIPE_SKID_EN undefined:
  - Single main register, no skid.
  - in_ready = !out_valid || out_ready, a combinational path from out_ready.
  - All other behaviour is identical.

## Test plan
- Reset:
  - Drive rst=0 mid-traffic -> all outputs 0 and in_ready=0 immediately.
  - Release rst -> in_ready=1 next cycle.
- Streaming: in_valid=1 and out_ready=1 for 8 cycles with in_data=1..8 -> out_data=1..8 delivered in order, each one cycle after acceptance, no gaps.
- Stall, skid build:
  - out_ready=0 for 3 cycles while in_valid=1 with data 0xA, 0xB.
  - With PIPE_SKID_EN: 0xA held on outputs, 0xB accepted into skid, then in_ready=0, stall_cnt=3.
  - Set out_ready=1 -> 0xA then 0xB delivered on consecutive cycles.
  - Without PIPE_SKID_EN: in_ready=0 during the stall and 0xB accepted only on release.
- Flush: an entry is held in main, with skid also full when configured, then flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, incoming entry absent, stall_cnt unchanged.
- Saturation: CNT_W=4 with out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt stops at 15.
- Flush plus out transfer: out_valid=1, out_ready=1, flush=1 in the same cycle -> main cleared, no new entry loaded, out_valid=0 next cycle.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: reusable pipeline-boundary register.
// It carries a data payload, a control bundle and a destination index.
// Inputs and outputs use a valid/ready handshake. The block also supports
// flush-to-bubble and keeps a saturating count of stall cycles.
//
// Optional feature macro: PIPE_SKID_EN
//   defined   -> two-entry buffer (main + skid). in_ready depends only on
//                held state, so there is no combinational path from out_ready.
//   undefined -> single main register. in_ready = !out_valid || out_ready.
//
// Handshake: an entry moves on a rising edge where valid && ready are both
// high. The sender holds its payload stable until that edge. The receiver
// may change ready at any time. A flush edge kills every held entry and the
// incoming entry, and it overrides a simultaneous output transfer.
module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 9,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [REG_W-1:0]  in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [REG_W-1:0]  out_dest,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [REG_W-1:0]  main_dest;
    logic [CNT_W-1:0]  cnt_q;

    logic in_xfer;
    logic main_free;

    assign in_xfer   = in_valid && in_ready;
    // Main can take a new entry if it is empty or is being drained this edge.
    assign main_free = !main_valid || out_ready;

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_dest  = main_dest;
    // A bubble must never carry write enables downstream.
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign stall_cnt = cnt_q;

`ifdef PIPE_SKID_EN
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [REG_W-1:0]  skid_dest;

    // in_ready depends only on the skid flag and reset, never on out_ready.
    assign in_ready = rst && !skid_valid;

    // Main/skid update. Flush wins. A drain refills main from skid first,
    // otherwise from an input transfer. A stalled input goes to skid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_ctrl  <= '0;
            main_dest  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
            skid_dest  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_data  <= skid_data;
                main_ctrl  <= skid_ctrl;
                main_dest  <= skid_dest;
                skid_valid <= 1'b0;
            end else if (in_xfer) begin
                main_valid <= 1'b1;
                main_data  <= in_data;
                main_ctrl  <= in_ctrl;
                main_dest  <= in_dest;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
            skid_ctrl  <= in_ctrl;
            skid_dest  <= in_dest;
        end
    end
`else
    // Accept an entry whenever main will be free at the coming edge.
    assign in_ready = rst && main_free;

    // Main register update. Flush wins. Otherwise main refills or empties
    // when free, and holds unchanged during a stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_ctrl  <= '0;
            main_dest  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
        end else if (main_free) begin
            main_valid <= in_xfer;
            if (in_xfer) begin
                main_data <= in_data;
                main_ctrl <= in_ctrl;
                main_dest <= in_dest;
            end
        end
    end
`endif

    // Count stalled cycles, but not flush cycles. The count saturates and
    // is cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (main_valid && !out_ready && !flush && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule
